// File: rtl/flag_ctrl.sv
// Flag controller: commits Z/V/N from the EX stage and resolves the condition
// of a branch in ID, either by forwarding in-flight flags or by stalling once.
module flag_ctrl #(
  parameter bit FWD_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_stall,
  input  logic [3:0]  ex_opcode,
  input  logic [15:0] ex_result,
  input  logic        ex_ovfl,
  input  logic        br_valid,
  input  logic [2:0]  br_ccc,
  output logic        Z,
  output logic        V,
  output logic        N,
  output logic        br_ready,
  output logic        br_taken,
  output logic        flag_stall
);

  typedef enum logic {
    S_EVAL = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t r_state;
  logic   r_z, r_v, r_n;

  logic w_upd_z, w_upd_vn, w_writer;
  logic w_z_new, w_v_new, w_n_new;
  logic w_fz, w_fv, w_fn;
  logic w_cond;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_upd_z  = 1'b0;
    w_upd_vn = 1'b0;
    if (ex_valid) begin
      unique case (ex_opcode)
        4'b0000, 4'b0001:          begin w_upd_z = 1'b1; w_upd_vn = 1'b1; end
        4'b0010, 4'b0100,
        4'b0101, 4'b0110:          w_upd_z = 1'b1;
        default:                   ;
      endcase
    end
  end

  assign w_writer = w_upd_z | w_upd_vn;
  assign w_z_new  = (ex_result == 16'h0000);
  assign w_n_new  = ex_result[15];
  assign w_v_new  = ex_ovfl;

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_z <= 1'b0;
      r_v <= 1'b0;
      r_n <= 1'b0;
    end else if (!ex_stall) begin
      if (w_upd_z) r_z <= w_z_new;
      if (w_upd_vn) begin
        r_v <= w_v_new;
        r_n <= w_n_new;
      end
    end
  end

  // Stall-mode FSM; with forwarding enabled it never leaves EVAL.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_EVAL;
    end else begin
      unique case (r_state)
        S_EVAL: if (!FWD_EN && br_valid && w_writer && !ex_stall) r_state <= S_WAIT;
        S_WAIT: r_state <= S_EVAL;
        default: r_state <= S_EVAL;
      endcase
    end
  end

  // Forwarding applies even while EX is frozen: the branch sees what will commit.
  assign w_fz = (FWD_EN && w_upd_z)  ? w_z_new : r_z;
  assign w_fv = (FWD_EN && w_upd_vn) ? w_v_new : r_v;
  assign w_fn = (FWD_EN && w_upd_vn) ? w_n_new : r_n;

  always_comb begin
    w_cond = 1'b0;
    unique case (br_ccc)
      3'b000: w_cond = ~w_fz;
      3'b001: w_cond = w_fz;
      3'b010: w_cond = ~w_fz & ~w_fn;
      3'b011: w_cond = w_fn;
      3'b100: w_cond = w_fz | (~w_fz & ~w_fn);
      3'b101: w_cond = w_fn | w_fz;
      3'b110: w_cond = w_fv;
      3'b111: w_cond = 1'b1;
      default: w_cond = 1'b0;
    endcase
  end

  always_comb begin
    br_ready   = 1'b0;
    flag_stall = 1'b0;
    if (FWD_EN || r_state == S_WAIT) begin
      br_ready = br_valid;
    end else begin
      br_ready   = br_valid & ~w_writer;
      flag_stall = br_valid & w_writer;
    end
  end

  assign br_taken = br_ready & w_cond;
  assign Z = r_z;
  assign V = r_v;
  assign N = r_n;

endmodule

// File: tb/tb_flag_ctrl.sv
// Directed bench for flag_ctrl: one forwarding instance and one stalling
// instance share the same stimulus; expected values are hand-computed.
module tb_flag_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_stall, ex_ovfl, br_valid;
  logic [3:0]  ex_opcode;
  logic [15:0] ex_result;
  logic [2:0]  br_ccc;

  logic f_z, f_v, f_n, f_ready, f_taken, f_stall;
  logic s_z, s_v, s_n, s_ready, s_taken, s_stall;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  flag_ctrl #(.FWD_EN(1'b1)) u_fwd (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_stall(ex_stall),
    .ex_opcode(ex_opcode), .ex_result(ex_result), .ex_ovfl(ex_ovfl),
    .br_valid(br_valid), .br_ccc(br_ccc),
    .Z(f_z), .V(f_v), .N(f_n),
    .br_ready(f_ready), .br_taken(f_taken), .flag_stall(f_stall)
  );

  flag_ctrl #(.FWD_EN(1'b0)) u_stl (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_stall(ex_stall),
    .ex_opcode(ex_opcode), .ex_result(ex_result), .ex_ovfl(ex_ovfl),
    .br_valid(br_valid), .br_ccc(br_ccc),
    .Z(s_z), .V(s_v), .N(s_n),
    .br_ready(s_ready), .br_taken(s_taken), .flag_stall(s_stall)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge, leaving 1 time unit for outputs to settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic st, input logic [3:0] op,
                       input logic [15:0] res, input logic ov,
                       input logic bv, input logic [2:0] ccc);
    ex_valid = v; ex_stall = st; ex_opcode = op; ex_result = res; ex_ovfl = ov;
    br_valid = bv; br_ccc = ccc;
    #1;
  endtask

  task automatic check_flags(input string tag, input logic z, input logic v, input logic n);
    check({tag, "_fwd_zvn"}, {13'd0, f_z, f_v, f_n}, {13'd0, z, v, n});
    check({tag, "_stl_zvn"}, {13'd0, s_z, s_v, s_n}, {13'd0, z, v, n});
  endtask

  task automatic check_fwd(input string tag, input logic rdy, input logic tkn, input logic stl);
    check({tag, "_fwd_rts"}, {13'd0, f_ready, f_taken, f_stall}, {13'd0, rdy, tkn, stl});
  endtask

  task automatic check_stl(input string tag, input logic rdy, input logic tkn, input logic stl);
    check({tag, "_stl_rts"}, {13'd0, s_ready, s_taken, s_stall}, {13'd0, rdy, tkn, stl});
  endtask

  logic [7:0] exp_taken;

  initial begin
    rst = 1'b1;
    drive(0, 0, 4'h0, 16'h0, 0, 0, 3'b000);
    step();
    step();
    check_flags("reset", 0, 0, 0);
    check_fwd("reset", 0, 0, 0);
    check_stl("reset", 0, 0, 0);
    rst = 1'b0;

    // Idle branch EQ on cleared flags
    drive(0, 0, 4'h0, 16'h0, 0, 1, 3'b001);
    check_fwd("idle_eq", 1, 0, 0);
    check_stl("idle_eq", 1, 0, 0);
    step();

    // SUB result 0 commits Z=1
    drive(1, 0, 4'b0001, 16'h0000, 0, 0, 3'b000);
    check_stl("sub_nobr", 0, 0, 0);
    step();
    check_flags("sub_commit", 1, 0, 0);
    drive(0, 0, 4'h0, 16'h0, 0, 1, 3'b001);
    check_fwd("sub_eq", 1, 1, 0);
    check_stl("sub_eq", 1, 1, 0);
    step();

    // ADD 8000 ovfl with LT branch in the same cycle
    drive(1, 0, 4'b0000, 16'h8000, 1, 1, 3'b011);
    check_fwd("add_lt", 1, 1, 0);
    check_stl("add_lt", 0, 0, 1);
    step();
    check_flags("add_commit", 0, 1, 1);
    drive(0, 0, 4'h0, 16'h0, 0, 1, 3'b011);
    check_stl("add_wait", 1, 1, 0);
    check_fwd("add_after", 1, 1, 0);
    step();

    // XOR result 0 held by ex_stall for 3 cycles, EQ branch waiting
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 4'b0010, 16'h0000, 0, 1, 3'b001);
      check_fwd($sformatf("hold%0d", i), 1, 1, 0);
      check_stl($sformatf("hold%0d", i), 0, 0, 1);
      step();
      check_flags($sformatf("hold%0d", i), 0, 1, 1);
    end
    drive(1, 0, 4'b0010, 16'h0000, 0, 1, 3'b001);
    check_stl("hold_commit", 0, 0, 1);
    step();
    check_flags("hold_commit", 1, 1, 1);
    drive(0, 0, 4'h0, 16'h0, 0, 1, 3'b001);
    check_stl("hold_wait", 1, 1, 0);
    step();

    // Z-only XOR result 0001 keeps V/N
    drive(1, 0, 4'b0010, 16'h0001, 0, 0, 3'b000);
    step();
    check_flags("xor_keep", 0, 1, 1);

    // Non-writer opcode with zero result changes nothing
    drive(1, 0, 4'b0011, 16'h0000, 0, 0, 3'b000);
    check_stl("nonwr_nobr", 0, 0, 0);
    step();
    check_flags("nonwriter", 0, 1, 1);

    // All condition codes against Z=0 V=1 N=1
    exp_taken = 8'b1110_1001;
    for (int c = 0; c < 8; c++) begin
      drive(0, 0, 4'h0, 16'h0, 0, 1, 3'(c));
      check_fwd($sformatf("ccc%0d", c), 1, exp_taken[c], 0);
      check_stl($sformatf("ccc%0d", c), 1, exp_taken[c], 0);
    end
    step();

    // Flush in WAIT: branch withdrawn
    drive(1, 0, 4'b0101, 16'h0000, 0, 1, 3'b001);
    check_stl("sra_stall", 0, 0, 1);
    step();
    check_flags("sra_commit", 1, 1, 1);
    drive(0, 0, 4'h0, 16'h0, 0, 0, 3'b001);
    check_stl("flush_wait", 0, 0, 0);
    step();
    drive(1, 0, 4'b0100, 16'h0000, 0, 1, 3'b001);
    check_stl("after_flush", 0, 0, 1);

    // Enter WAIT, then reset there with a writer present: reset wins
    step();
    rst = 1'b1;
    drive(1, 0, 4'b0000, 16'h8000, 1, 1, 3'b011);
    check_stl("rst_in_wait", 1, 1, 0);
    step();
    rst = 1'b0;
    drive(0, 0, 4'h0, 16'h0, 0, 0, 3'b000);
    check_flags("post_rst", 0, 0, 0);
    check_fwd("post_rst", 0, 0, 0);
    check_stl("post_rst", 0, 0, 0);
    drive(1, 0, 4'b0000, 16'h0001, 0, 1, 3'b000);
    check_stl("post_rst_eval", 0, 0, 1);
    check_fwd("post_rst_eval", 1, 1, 0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
